// File: rtl/application_selector_button_ctrl.sv
// Avalon-MM master for the button PIO: programs irq_mask, services each irq with a debounce
// holdoff, and queues {level, edge} events into a small valid/ready FIFO.
module application_selector_button_ctrl #(
  parameter int              WIDTH          = 4,
  parameter logic [WIDTH-1:0] MASK_INIT     = {WIDTH{1'b1}},
  parameter int              HOLDOFF_CYCLES = 500000,
  parameter int              FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             overflow
);

  localparam int HW = $clog2(HOLDOFF_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    S_INIT_MASK, S_CLR_STALE, S_IDLE, S_RD_CAP, S_CAP_WAIT,
    S_CLR_CAP, S_RD_LVL, S_LVL_WAIT, S_PUSH, S_HOLDOFF
  } state_t;

  state_t           r_state, w_next;
  logic [HW-1:0]    r_hcnt;
  logic [WIDTH-1:0] r_cap, r_lvl;
  logic [2*WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_cs, w_wr;
  logic [1:0]       w_addr;
  logic [31:0]      w_wdata;
  logic             w_full, w_pop, w_push, w_hold_done;
  logic             w_unused;

  assign w_unused    = ^pio_readdata[31:WIDTH];
  assign w_hold_done = (r_hcnt == HW'(HOLDOFF_CYCLES - 1));
  assign evt_valid   = (r_count != '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_pop       = evt_valid & evt_ready;
  assign w_push      = (r_state == S_PUSH) & (~w_full | w_pop);
  assign evt_edges   = evt_valid ? r_mem[r_rd_ptr][WIDTH-1:0]       : '0;
  assign evt_level   = evt_valid ? r_mem[r_rd_ptr][2*WIDTH-1:WIDTH] : '0;

  // Bus outputs are registered from the next state so each access lines up with its state.
  // INIT_MASK lingers one cycle after reset because the bus is still idle on entry.
  always_comb begin
    w_next  = r_state;
    w_cs    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = 2'd0;
    w_wdata = '0;
    case (r_state)
      S_INIT_MASK: w_next = pio_chipselect ? S_CLR_STALE : S_INIT_MASK;
      S_CLR_STALE: w_next = S_IDLE;
      S_IDLE:      w_next = (enable && pio_irq) ? S_RD_CAP : S_IDLE;
      S_RD_CAP:    w_next = S_CAP_WAIT;
      S_CAP_WAIT:  w_next = S_CLR_CAP;
      S_CLR_CAP:   w_next = (r_cap != '0) ? S_RD_LVL : S_IDLE;
      S_RD_LVL:    w_next = S_LVL_WAIT;
      S_LVL_WAIT:  w_next = S_PUSH;
      S_PUSH:      w_next = S_HOLDOFF;
      S_HOLDOFF:   w_next = w_hold_done ? S_CLR_STALE : S_HOLDOFF;
      default:     w_next = S_INIT_MASK;
    endcase
    case (w_next)
      S_INIT_MASK: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = 2'd2;
        w_wdata = 32'(MASK_INIT);
      end
      S_CLR_STALE, S_CLR_CAP: begin
        w_cs   = 1'b1;
        w_wr   = 1'b1;
        w_addr = 2'd3;
      end
      S_RD_CAP: begin
        w_cs   = 1'b1;
        w_addr = 2'd3;
      end
      S_RD_LVL: w_cs = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_INIT_MASK;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= 2'd0;
      pio_writedata  <= '0;
      r_hcnt         <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      overflow       <= 1'b0;
    end else begin
      r_state        <= w_next;
      pio_chipselect <= w_cs;
      pio_write_n    <= ~w_wr;
      pio_address    <= w_addr;
      pio_writedata  <= w_wdata;
      if (r_state == S_HOLDOFF && !w_hold_done) r_hcnt <= r_hcnt + 1'b1;
      else                                      r_hcnt <= '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (r_state == S_PUSH && w_full && !w_pop) overflow <= 1'b1;
    end
  end

  // Datapath capture and FIFO storage carry no reset; outputs are gated by evt_valid.
  always_ff @(posedge clk) begin
    if (r_state == S_CAP_WAIT) r_cap <= pio_readdata[WIDTH-1:0];
    if (r_state == S_LVL_WAIT) r_lvl <= pio_readdata[WIDTH-1:0];
    if (w_push) r_mem[r_wr_ptr] <= {r_lvl, r_cap};
  end

endmodule
